// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward selects,
// stage records and flush-depth constants.
package pipe_pkg;

  // Records store register addresses at this width; REG_ADDR_W must not exceed it.
  localparam int REC_RD_W = 8;

  localparam int FLUSH_IF_ID  = 1;
  localparam int FLUSH_ID_EX  = 2;
  localparam int FLUSH_EX_MEM = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [REC_RD_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_rec_t;

  typedef struct packed {
    stage_rec_t          base;
    logic [REC_RD_W-1:0] rs1;
    logic [REC_RD_W-1:0] rs2;
    logic                uses_rs1;
    logic                uses_rs2;
  } ex_rec_t;

  // x0 is hard-wired zero, so it never produces a dependency.
  function automatic logic produces(input stage_rec_t p, input logic [REC_RD_W-1:0] rs,
                                    input logic uses);
    return p.valid && p.reg_write && (p.rd != '0) && uses && (p.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record: loads d when load=1, otherwise takes a bubble.
// A bubble is all zeros (valid=0, rd=0), the same value reset leaves behind.
module hazard_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
    else           q <= '0;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and operand-forward control for the five-stage core.
// FORWARDING_EN defined: EX-stage forwarding, only load-use stalls; undefined: interlock only.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int EX_W  = $bits(ex_rec_t);
  localparam int REC_W = $bits(stage_rec_t);

  ex_rec_t             id_info;
  ex_rec_t             ex_r;
  stage_rec_t          mem_r;
  stage_rec_t          wb_r;
  logic [EX_W-1:0]     ex_q;
  logic [REC_W-1:0]    mem_q;
  logic [REC_W-1:0]    wb_q;
  logic [REC_RD_W-1:0] rs1_x;
  logic [REC_RD_W-1:0] rs2_x;
  logic                haz_ex;
  logic                haz_mem;
  logic                hazard;
  fwd_sel_t            sel_a;
  fwd_sel_t            sel_b;
  logic                ex_load;
  logic                mem_load;

  assign rs1_x = REC_RD_W'(id_rs1);
  assign rs2_x = REC_RD_W'(id_rs2);

  always_comb begin
    id_info                = '0;
    id_info.base.valid     = id_valid;
    id_info.base.rd        = REC_RD_W'(id_rd);
    id_info.base.reg_write = id_reg_write;
    id_info.base.mem_read  = id_mem_read;
    id_info.rs1            = rs1_x;
    id_info.rs2            = rs2_x;
    id_info.uses_rs1       = id_uses_rs1;
    id_info.uses_rs2       = id_uses_rs2;
  end

  assign ex_r  = ex_q;
  assign mem_r = mem_q;
  assign wb_r  = wb_q;

  // WB producers are covered by the write-through register file, so only EX/MEM matter.
  assign haz_ex  = id_valid && (produces(ex_r.base, rs1_x, id_uses_rs1) ||
                                produces(ex_r.base, rs2_x, id_uses_rs2));
  assign haz_mem = id_valid && (produces(mem_r, rs1_x, id_uses_rs1) ||
                                produces(mem_r, rs2_x, id_uses_rs2));

`ifdef FORWARDING_EN
  assign hazard = haz_ex && ex_r.base.mem_read;

  // MEM holds the younger value, so it wins over WB.
  function automatic fwd_sel_t pick(input logic [REC_RD_W-1:0] rs, input logic uses);
    if (produces(mem_r, rs, uses))     return FWD_MEM;
    else if (produces(wb_r, rs, uses)) return FWD_WB;
    else                               return FWD_RF;
  endfunction

  assign sel_a = ex_r.base.valid ? pick(ex_r.rs1, ex_r.uses_rs1) : FWD_RF;
  assign sel_b = ex_r.base.valid ? pick(ex_r.rs2, ex_r.uses_rs2) : FWD_RF;
`else
  assign hazard = haz_ex || haz_mem;
  assign sel_a  = FWD_RF;
  assign sel_b  = FWD_RF;
`endif

  // A taken branch squashes the ID instruction, so it overrides any stall.
  always_comb begin
    stall        = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    if (rst_n) begin
      if (branch_taken) begin
        flush_if_id  = (FLUSH_DEPTH >= FLUSH_IF_ID);
        flush_id_ex  = (FLUSH_DEPTH >= FLUSH_ID_EX);
        flush_ex_mem = (FLUSH_DEPTH >= FLUSH_EX_MEM);
      end else begin
        stall = hazard;
      end
      fwd_a = sel_a;
      fwd_b = sel_b;
    end
  end

  assign ex_load  = id_valid && !stall && !flush_id_ex;
  assign mem_load = !flush_ex_mem;

  hazard_stage_reg #(.W(EX_W)) u_ex_rec (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ex_load),
    .d     (id_info),
    .q     (ex_q)
  );

  hazard_stage_reg #(.W(REC_W)) u_mem_rec (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mem_load),
    .d     (ex_r.base),
    .q     (mem_q)
  );

  hazard_stage_reg #(.W(REC_W)) u_wb_rec (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .d     (mem_r),
    .q     (wb_q)
  );

  assign ex_valid  = ex_r.base.valid;
  assign mem_valid = mem_r.valid;
  assign wb_valid  = wb_r.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           stall_count <= '0;
    else if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
  end

  // Fields that only one build configuration reads.
  logic unused_ok;
  assign unused_ok = &{1'b0, wb_r.mem_read, wb_r.reg_write, wb_r.rd, mem_r.mem_read,
                       ex_r.rs1, ex_r.rs2, ex_r.uses_rs1, ex_r.uses_rs2, haz_mem};

endmodule
